// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic light controller.
//   Interval codes presented to the time-parameter store.
//   One-hot lamp codes, ordered {red, yellow, green}.
//   Sequencer state enumeration.
package traffic_pkg;

  localparam logic [1:0] IV_BASE = 2'b00;
  localparam logic [1:0] IV_EXT  = 2'b01;
  localparam logic [1:0] IV_YEL  = 2'b10;

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  // Four bits wide so that unused encodings exist and are recovered explicitly.
  typedef enum logic [3:0] {
    ST_MG1  = 4'd0,
    ST_MG2  = 4'd1,
    ST_MGX  = 4'd2,
    ST_MY   = 4'd3,
    ST_WALK = 4'd4,
    ST_SG   = 4'd5,
    ST_SGX  = 4'd6,
    ST_SY   = 4'd7
  } state_e;

endpackage

// File: rtl/traffic_light_fsm_walk_register.sv
// Pedestrian request latch.
//   clk_i, rst_i : clock, synchronous active-high reset (clears the latch)
//   set_i        : walk request pulse
//   clr_i        : request being served this cycle
//   pending_o    : latched request
// A request arriving on the same cycle as the clear wins, so it is not lost.
module walk_register (
  input  logic clk_i,
  input  logic rst_i,
  input  logic set_i,
  input  logic clr_i,
  output logic pending_o
);

  logic pending_q;
  logic pending_d;

  always_comb begin
    pending_d = pending_q;
    if (set_i) begin
      pending_d = 1'b1;
    end else if (clr_i) begin
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign pending_o = pending_q;

endmodule

// File: rtl/traffic_light_fsm.sv
// Traffic light sequencer.
//   clk_i, rst_i     : clock, synchronous active-high reset
//   prog_sync_i      : restart the sequence at main green
//   sensor_i         : side-street car present
//   walk_request_i   : pedestrian request pulse
//   expired_i        : interval timer expiry pulse
//   interval_o       : duration code for the time-parameter store
//   start_timer_o    : timer reload pulse, one cycle per state entry
//   main_light_o     : main-street lamps {red, yellow, green}
//   side_light_o     : side-street lamps {red, yellow, green}
//   walk_lamp_o      : pedestrian walk lamp
//   walk_reset_o     : pulse when a pending walk request is served
//
// state | meaning
// MG1   | main green, first base interval
// MG2   | main green, second base interval (no side car)
// MGX   | main green, extended interval (side car waiting)
// MY    | main yellow
// WALK  | all red, walk lamp on
// SG    | side green, base interval
// SGX   | side green, extended interval
// SY    | side yellow
module traffic_light_fsm
  import traffic_pkg::*;
#(
  parameter bit SIDE_EXTEND = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       prog_sync_i,
  input  logic       sensor_i,
  input  logic       walk_request_i,
  input  logic       expired_i,
  output logic [1:0] interval_o,
  output logic       start_timer_o,
  output logic [2:0] main_light_o,
  output logic [2:0] side_light_o,
  output logic       walk_lamp_o,
  output logic       walk_reset_o
);

  state_e     state_q, state_d;
  logic [1:0] interval_q, interval_d;
  logic       start_timer_q, start_timer_d;
  logic [2:0] main_light_q, main_light_d;
  logic [2:0] side_light_q, side_light_d;
  logic       walk_lamp_q, walk_lamp_d;
  logic       walk_reset_q, walk_reset_d;
  logic       walk_pending;
  logic       advance;

  // An expiry seen while the timer is being reloaded belongs to the old interval.
  assign advance = expired_i && !start_timer_q;

  walk_register u_walk_register (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .set_i     (walk_request_i),
    .clr_i     (walk_reset_d),
    .pending_o (walk_pending)
  );

  always_comb begin
    state_d       = state_q;
    start_timer_d = 1'b0;
    walk_reset_d  = 1'b0;
    if (prog_sync_i) begin
      state_d       = ST_MG1;
      start_timer_d = 1'b1;
    end else begin
      unique case (state_q)
        ST_MG1: if (advance) begin
          state_d       = sensor_i ? ST_MGX : ST_MG2;
          start_timer_d = 1'b1;
        end
        ST_MG2, ST_MGX: if (advance) begin
          state_d       = ST_MY;
          start_timer_d = 1'b1;
        end
        ST_MY: if (advance) begin
          state_d       = walk_pending ? ST_WALK : ST_SG;
          start_timer_d = 1'b1;
          walk_reset_d  = walk_pending;
        end
        ST_WALK: if (advance) begin
          state_d       = ST_SG;
          start_timer_d = 1'b1;
        end
        ST_SG: if (advance) begin
          state_d       = (SIDE_EXTEND && sensor_i) ? ST_SGX : ST_SY;
          start_timer_d = 1'b1;
        end
        ST_SGX: if (advance) begin
          state_d       = ST_SY;
          start_timer_d = 1'b1;
        end
        ST_SY: if (advance) begin
          state_d       = ST_MG1;
          start_timer_d = 1'b1;
        end
        default: begin
          state_d       = ST_MG1;
          start_timer_d = 1'b1;
        end
      endcase
    end
  end

  // Outputs decoded from the next state so they change on the same edge as the state.
  always_comb begin
    interval_d   = IV_BASE;
    main_light_d = LAMP_R;
    side_light_d = LAMP_R;
    walk_lamp_d  = 1'b0;
    case (state_d)
      ST_MG1, ST_MG2: main_light_d = LAMP_G;
      ST_MGX: begin
        interval_d   = IV_EXT;
        main_light_d = LAMP_G;
      end
      ST_MY: begin
        interval_d   = IV_YEL;
        main_light_d = LAMP_Y;
      end
      ST_WALK: begin
        interval_d  = IV_EXT;
        walk_lamp_d = 1'b1;
      end
      ST_SG: side_light_d = LAMP_G;
      ST_SGX: begin
        interval_d   = IV_EXT;
        side_light_d = LAMP_G;
      end
      ST_SY: begin
        interval_d   = IV_YEL;
        side_light_d = LAMP_Y;
      end
      default: main_light_d = LAMP_G;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= ST_MG1;
      interval_q    <= IV_BASE;
      start_timer_q <= 1'b1;
      main_light_q  <= LAMP_G;
      side_light_q  <= LAMP_R;
      walk_lamp_q   <= 1'b0;
      walk_reset_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      interval_q    <= interval_d;
      start_timer_q <= start_timer_d;
      main_light_q  <= main_light_d;
      side_light_q  <= side_light_d;
      walk_lamp_q   <= walk_lamp_d;
      walk_reset_q  <= walk_reset_d;
    end
  end

  assign interval_o    = interval_q;
  assign start_timer_o = start_timer_q;
  assign main_light_o  = main_light_q;
  assign side_light_o  = side_light_q;
  assign walk_lamp_o   = walk_lamp_q;
  assign walk_reset_o  = walk_reset_q;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Bench for traffic_light_fsm: two instances (side extension on = index 1,
// off = index 0) share the street inputs; each has its own timer model and
// reference sequence model.
module tb_traffic_light_fsm;

  logic       clk_i = 1'b0;
  logic       rst_i, prog_sync_i, sensor_i, walk_request_i;
  logic [1:0] expired_v;
  logic [1:0] iv     [2];
  logic       st_tmr [2];
  logic [2:0] mainl  [2];
  logic [2:0] sidel  [2];
  logic       wlamp  [2];
  logic       wrst   [2];

  always #5 clk_i = ~clk_i;

  traffic_light_fsm #(.SIDE_EXTEND(1'b0)) u_dut_base (
    .clk_i(clk_i), .rst_i(rst_i), .prog_sync_i(prog_sync_i), .sensor_i(sensor_i),
    .walk_request_i(walk_request_i), .expired_i(expired_v[0]),
    .interval_o(iv[0]), .start_timer_o(st_tmr[0]), .main_light_o(mainl[0]),
    .side_light_o(sidel[0]), .walk_lamp_o(wlamp[0]), .walk_reset_o(wrst[0])
  );

  traffic_light_fsm #(.SIDE_EXTEND(1'b1)) u_dut_ext (
    .clk_i(clk_i), .rst_i(rst_i), .prog_sync_i(prog_sync_i), .sensor_i(sensor_i),
    .walk_request_i(walk_request_i), .expired_i(expired_v[1]),
    .interval_o(iv[1]), .start_timer_o(st_tmr[1]), .main_light_o(mainl[1]),
    .side_light_o(sidel[1]), .walk_lamp_o(wlamp[1]), .walk_reset_o(wrst[1])
  );

  string m_st     [2];
  bit    m_start  [2];
  bit    m_wp     [2];
  bit    m_wreset [2];
  int    cnt      [2];
  int    n_vec = 0;
  int    n_err = 0;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] iv_of(input string s);
    if (s == "MGX" || s == "SGX" || s == "WALK") return 2'b01;
    if (s == "MY" || s == "SY") return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [2:0] main_of(input string s);
    if (s == "MG1" || s == "MG2" || s == "MGX") return 3'b001;
    if (s == "MY") return 3'b010;
    return 3'b100;
  endfunction

  function automatic logic [2:0] side_of(input string s);
    if (s == "SG" || s == "SGX") return 3'b001;
    if (s == "SY") return 3'b010;
    return 3'b100;
  endfunction

  function automatic int dur(input logic [1:0] code);
    if (code == 2'b00) return 4;
    if (code == 2'b01) return 2;
    return 1;
  endfunction

  function automatic string nxt(input string s, input bit sens, input bit wp, input bit se);
    case (s)
      "MG1":        return sens ? "MGX" : "MG2";
      "MG2", "MGX": return "MY";
      "MY":         return wp ? "WALK" : "SG";
      "WALK":       return "SG";
      "SG":         return (se && sens) ? "SGX" : "SY";
      "SGX":        return "SY";
      default:      return "MG1";
    endcase
  endfunction

  // Called just after a falling edge; returns just after the next falling edge.
  task automatic step(input bit r, input bit ps, input bit sn, input bit wr, input bit xe);
    rst_i          = r;
    prog_sync_i    = ps;
    sensor_i       = sn;
    walk_request_i = wr;
    for (int k = 0; k < 2; k++) expired_v[k] = (cnt[k] == 1) || xe;
    @(posedge clk_i);
    for (int k = 0; k < 2; k++) begin
      bit    adv;
      string ns;
      adv = expired_v[k] && !m_start[k];
      if (m_start[k]) cnt[k] = dur(iv_of(m_st[k]));
      else if (cnt[k] > 0) cnt[k]--;
      m_wreset[k] = 1'b0;
      if (r) begin
        m_st[k] = "MG1"; m_start[k] = 1'b1; m_wp[k] = 1'b0;
      end else begin
        if (ps) begin
          m_st[k] = "MG1"; m_start[k] = 1'b1;
        end else if (adv) begin
          ns          = nxt(m_st[k], sn, m_wp[k], k == 1);
          m_wreset[k] = (ns == "WALK");
          m_st[k]     = ns;
          m_start[k]  = 1'b1;
        end else begin
          m_start[k] = 1'b0;
        end
        if (wr) m_wp[k] = 1'b1;
        else if (m_wreset[k]) m_wp[k] = 1'b0;
      end
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("u%0d.interval(%s)", k, m_st[k]), {6'd0, iv[k]}, {6'd0, iv_of(m_st[k])});
      chk($sformatf("u%0d.start_timer(%s)", k, m_st[k]), {7'd0, st_tmr[k]}, {7'd0, m_start[k]});
      chk($sformatf("u%0d.main_light(%s)", k, m_st[k]), {5'd0, mainl[k]}, {5'd0, main_of(m_st[k])});
      chk($sformatf("u%0d.side_light(%s)", k, m_st[k]), {5'd0, sidel[k]}, {5'd0, side_of(m_st[k])});
      chk($sformatf("u%0d.walk_lamp(%s)", k, m_st[k]), {7'd0, wlamp[k]}, {7'd0, m_st[k] == "WALK"});
      chk($sformatf("u%0d.walk_reset(%s)", k, m_st[k]), {7'd0, wrst[k]}, {7'd0, m_wreset[k]});
    end
    @(negedge clk_i);
  endtask

  task automatic wait_state(input string s, input bit sn);
    int n = 0;
    while (m_st[1] != s && n < 200) begin
      step(1'b0, 1'b0, sn, 1'b0, 1'b0);
      n++;
    end
    chk({"reach_", s}, {7'd0, n < 200}, 8'd1);
  endtask

  initial begin
    int n;
    rst_i = 1'b1; prog_sync_i = 1'b0; sensor_i = 1'b0; walk_request_i = 1'b0;
    expired_v = 2'b00;
    for (int k = 0; k < 2; k++) begin
      m_st[k] = "MG1"; m_start[k] = 1'b1; m_wp[k] = 1'b0; m_wreset[k] = 1'b0; cnt[k] = 0;
    end
    @(negedge clk_i);

    // Reset values, then plain cycling with no side traffic.
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (60) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Side traffic present throughout: extended greens.
    repeat (60) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Walk request during main green.
    wait_state("MG1", 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (80) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Walk request arriving on the very edge that enters WALK.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    n = 0;
    while (!(m_st[1] == "MY" && !m_start[1] && cnt[1] == 1) && n < 200) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      n++;
    end
    chk("reach_my_expiry", {7'd0, n < 200}, 8'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (80) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // prog_sync together with an expiry during extended side green.
    wait_state("SGX", 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    repeat (20) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Reset held for three cycles during main yellow, with a request pending.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_state("MY", 1'b0);
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (40) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Randomised traffic, requests, resyncs, resets and stray expiries.
    sensor_i = 1'b0;
    repeat (3000) begin
      bit sn;
      sn = sensor_i;
      if ($urandom_range(0, 9) == 0) sn = ~sn;
      step($urandom_range(0, 199) == 0, $urandom_range(0, 99) == 0, sn,
           $urandom_range(0, 19) == 0, $urandom_range(0, 49) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/traffic_light_fsm.md
Name: traffic_light_fsm

Overview:
- Sequencing state machine of the traffic light controller.
- Selects which programmed duration (interval code) the time-parameter store presents to the interval timer, and pulses start_timer on every state entry.
- Advances on the timer's expired pulse and drives the main-street, side-street and walk lamps.
- Handles the side-street traffic sensor, the latched pedestrian walk request and the prog_sync resynchronisation strobe.

Parameters:
SIDE_EXTEND, 1, when 1 the side-street green is extended by t_EXT if sensor is high at base-time expiry; when 0 side green is t_BASE only.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
prog_sync  in  1  reprogramming strobe; restarts the sequence at main green
sensor  in  1  side-street car present, already synchronised
walk_request  in  1  one-cycle pedestrian request pulse, already debounced
expired  in  1  one-cycle pulse from the interval timer
interval  out  2  interval code to the time-parameter store: 00 base, 01 extended, 10 yellow
start_timer  out  1  one-cycle pulse; timer reloads from the current value
main_light  out  3  {red, yellow, green}, one-hot
side_light  out  3  {red, yellow, green}, one-hot
walk_lamp  out  1  pedestrian walk lamp
walk_reset  out  1  one-cycle pulse when a pending walk request is served

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named rst. All outputs are registered.
- States and programmed durations:
  MG1: main green, t_BASE.
  MG2: main green, t_BASE, or MGX: main green, t_EXT.
  MY: main yellow, t_YEL.
  WALK: all red, walk lamp on, t_EXT.
  SG: side green, t_BASE.
  SGX: side green, t_EXT.
  SY: side yellow, t_YEL.
- Transitions occur only on a cycle with expired=1 and start_timer=0:
  MG1 -> MGX if sensor=1, else MG2.
  MG2 or MGX -> MY.
  MY -> WALK if walk_pending=1, else SG.
  WALK -> SG.
  SG -> SGX if SIDE_EXTEND=1 and sensor=1, else SY.
  SGX -> SY.
  SY -> MG1.
- interval per state: MG1, MG2, SG = 00; MGX, SGX, WALK = 01; MY, SY = 10.
- State entry timing: on the cycle the state register changes, interval takes the new code and start_timer=1 for exactly that cycle. The timer therefore sees a stable code on the start edge.
- Expired ignored: an expired pulse coincident with start_timer=1 is ignored, since it belongs to the previous interval.
- Lamps are decoded from the next state and registered, so lamps change on the same edge as the state.
  In every non-WALK state, the street not shown green/yellow is red.
  WALK drives main=100, side=100, walk_lamp=1. walk_lamp=0 in all other states.
- walk_pending register:
  Set by walk_request=1 in any state.
  Cleared on entry to WALK, with walk_reset=1 for one cycle.
  If walk_request coincides with that clear, set wins and the request is served on the next cycle through MY.
- prog_sync=1 (any state, any cycle):
  Next state is MG1; start_timer=1; interval=00; walk_pending preserved.
  If held high, MG1 is re-entered and start_timer re-pulses every cycle.
  prog_sync takes priority over expired.
- Reset state: rst=1 forces state MG1, interval=00, start_timer=1, main_light=001, side_light=100, walk_lamp=0, walk_reset=0, walk_pending=0.
  The first cycle after rst deasserts has start_timer=0.
  Because the timer is reloaded continuously during reset, the sequence starts cleanly.
  Reset mid-interval discards the pending walk request.
- Undefined state encodings recover to MG1 on the next cycle with start_timer=1.

Decomposition:
- Package traffic_pkg holds:
  Interval codes IV_BASE=2'b00, IV_EXT=2'b01, IV_YEL=2'b10.
  Lamp codes LAMP_R=3'b100, LAMP_Y=3'b010, LAMP_G=3'b001.
  The state enumeration.
- One sub-module, walk_register: walk_pending set/clear with set-wins priority and rst clear.
- The FSM, interval decode and lamp decode stay in traffic_light_fsm.

Test Plan:
All scenarios use a bench timer model that asserts expired N cycles after start_timer, with N = 4 for code 00, 2 for code 01 and 1 for code 10.
1. Reset, sensor=0, walk_request never asserted: sequence MG1 -> MG2 -> MY -> SG -> SY -> MG1.
   interval sequence is 00, 00, 10, 00, 10, 00, with one start_timer pulse per entry.
   main_light sequence is 001, 001, 010, 100, 100.
2. sensor=1 throughout: MG1 -> MGX (interval 01, main 001) -> MY.
   SG -> SGX (interval 01, side 001) -> SY.
   Rerun with SIDE_EXTEND=0: SG goes directly to SY.
3. walk_request pulse during MG1: walk_reset pulses once on WALK entry.
   In WALK: main=100, side=100, walk_lamp=1, interval=01. SG follows WALK.
   The next cycle through goes MY -> SG directly.
4. walk_request on the same cycle as WALK entry: walk_reset=1 and walk_pending remains 1. The next MY goes to WALK again.
5. prog_sync during SGX, with expired pulsed on the same cycle: next state is MG1, interval=00, start_timer=1, main=001, side=100. The expired pulse causes no SY.
6. rst asserted during MY for 3 cycles: outputs take their reset values on the first rst edge, start_timer stays high during reset, and the sequence restarts from MG1.
